llc_bus_interface_unit: RTL

//  Downstream of the LLC: turns LLC bus-operation requests (READ, WRITE, INVALIDATE, RWIM) into timed system-bus transactions.

---
 rtl/llc_bus_pkg.sv | 30 +++
 rtl/biu_req_fifo.sv | 54 +++++
 rtl/llc_bus_interface_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/llc_bus_pkg.sv
// Shared types for the LLC <-> system-bus interface: bus operations, snoop
// results and the bus interface unit FSM states.
package llc_bus_pkg;

  localparam int BUS_ADDR_BITS        = 32;
  localparam int BUS_BYTE_OFFSET_BITS = 6;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_INVALIDATE = 2'd2,
    OP_RWIM       = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2
  } snp_rslt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_SNOOP = 3'd3,
    ST_DATA  = 3'd4,
    ST_RESP  = 3'd5
  } biu_state_t;

endpackage

// File: rtl/biu_req_fifo.sv
// Request buffer for the bus interface unit: power-of-two depth, wrapping
// pointers, extra count bit to tell full from empty.
module biu_req_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/llc_bus_interface_unit.sv
// Bus interface unit between the LLC and the system bus: queues LLC requests
// and runs each as arbitrate/address/snoop/data. Optional BIU_STATS_EN adds counters.
module llc_bus_interface_unit
  import llc_bus_pkg::*;
#(
  parameter int ADDR_BITS        = BUS_ADDR_BITS,
  parameter int BYTE_OFFSET_BITS = BUS_BYTE_OFFSET_BITS,
  parameter int FIFO_DEPTH       = 4,
  parameter int SNOOP_CYCLES     = 2,
  parameter int DATA_BEATS       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  bus_op_t                       req_op,
  input  logic [ADDR_BITS-1:0]          req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output bus_op_t                       resp_op,
  output logic [ADDR_BITS-1:0]          resp_addr,
  output snp_rslt_t                     resp_snoop,
  output logic                          bus_req,
  input  logic                          bus_gnt,
  output logic                          bus_addr_valid,
  output bus_op_t                       bus_op,
  output logic [ADDR_BITS-1:0]          bus_addr,
  input  logic                          bus_hit,
  input  logic                          bus_hitm,
  input  logic                          bus_data_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output biu_state_t                    state_dbg
`ifdef BIU_STATS_EN
  ,
  output logic [31:0]                   stat_ops [4],
  output logic [31:0]                   stat_hitm,
  output logic [31:0]                   stat_stall
`endif
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never depends on ready, and a response holds until accepted.

  localparam int ENTRY_W = ADDR_BITS + 2;
  localparam int SNP_W   = $clog2(SNOOP_CYCLES + 1);
  localparam int BEAT_W  = $clog2(DATA_BEATS + 1);
  localparam logic [ADDR_BITS-1:0] OFFSET_MASK =
    {{(ADDR_BITS-BYTE_OFFSET_BITS){1'b0}}, {BYTE_OFFSET_BITS{1'b1}}};

  biu_state_t           state_q, state_d;
  bus_op_t              txn_op;
  logic [ADDR_BITS-1:0] txn_addr;
  snp_rslt_t            snoop_q;
  logic [SNP_W-1:0]     snp_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 snp_last;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_dout;

  biu_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid && req_ready),
    .push_data ({req_op, req_addr & ~OFFSET_MASK}),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  assign req_ready = rst_n && !fifo_full;
  assign snp_last  = (snp_cnt == SNP_W'(SNOOP_CYCLES - 1));
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ARB;
        end
      end
      ST_ARB:   if (bus_gnt) state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_SNOOP;
      ST_SNOOP: begin
        if (snp_last) state_d = (txn_op == OP_INVALIDATE) ? ST_RESP : ST_DATA;
      end
      ST_DATA: begin
        if (bus_data_ack && beat_cnt == BEAT_W'(DATA_BEATS - 1)) state_d = ST_RESP;
      end
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant is only looked at in ARB; once won, the bus is held until RESP.
  always_comb begin
    bus_req        = (state_q == ST_ARB) || (state_q == ST_ADDR) ||
                     (state_q == ST_SNOOP) || (state_q == ST_DATA);
    bus_addr_valid = (state_q == ST_ADDR);
    bus_op         = bus_addr_valid ? txn_op : OP_READ;
    bus_addr       = bus_addr_valid ? txn_addr : '0;
    resp_valid     = (state_q == ST_RESP);
    resp_op        = txn_op;
    resp_addr      = txn_addr;
    resp_snoop     = snoop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_op   <= OP_READ;
      txn_addr <= '0;
      snoop_q  <= SNP_HIT;
      snp_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_pop) begin
        txn_op   <= bus_op_t'(fifo_dout[ENTRY_W-1 -: 2]);
        txn_addr <= fifo_dout[ADDR_BITS-1:0];
      end
      if (state_q == ST_SNOOP) begin
        snp_cnt <= snp_cnt + SNP_W'(1);
        if (snp_last) begin
          snoop_q <= bus_hitm ? SNP_HITM : (bus_hit ? SNP_HIT : SNP_NOHIT);
        end
      end else begin
        snp_cnt <= '0;
      end
      if (state_q == ST_DATA) begin
        if (bus_data_ack) beat_cnt <= beat_cnt + BEAT_W'(1);
      end else begin
        beat_cnt <= '0;
      end
    end
  end

`ifdef BIU_STATS_EN
  logic resp_fire;
  assign resp_fire = resp_valid && resp_ready;

  // All counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) stat_ops[i] <= '0;
      stat_hitm  <= '0;
      stat_stall <= '0;
    end else begin
      if (resp_fire) begin
        if (stat_ops[txn_op] != '1) stat_ops[txn_op] <= stat_ops[txn_op] + 32'd1;
        if (snoop_q == SNP_HITM && stat_hitm != '1) stat_hitm <= stat_hitm + 32'd1;
      end
      if (state_q == ST_ARB && !bus_gnt && stat_stall != '1) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
